// File: rtl/afifo_rd_streamer.sv
// Read-side FIFO consumer: prefetches into a 2-entry skid buffer and emits a valid/ready stream
// with optional fixed-length framing. Optional counters under AFIFO_RD_STREAMER_STATS_EN.
module afifo_rd_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int LAST_EVERY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  output logic                  rd_en,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
`ifdef AFIFO_RD_STREAMER_STATS_EN
  ,
  output logic [31:0]           words_out,
  output logic [31:0]           stall_cycles
`endif
);

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  pop;
  logic                  push;
  logic [2:0]            pending;

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = mem_q[head_q];
  assign pop       = out_valid && out_ready;
  assign push      = inflight_q && !flush;

  // Slots already claimed (buffered plus returning) after this cycle's pop frees one.
  assign pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en   = !rst && !empty && !flush && (pending < 3'd2);

  always_comb begin
    occ_d      = occ_q;
    inflight_d = inflight_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (flush) begin
      occ_d      = 2'd0;
      inflight_d = 1'b0;
      head_d     = 1'b0;
      tail_d     = 1'b0;
    end else begin
      inflight_d = rd_en;
      head_d     = head_q ^ pop;
      tail_d     = tail_q ^ push;
      occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      if (push) mem_q[tail_q] <= rd_data;
    end
  end

  generate
    if (LAST_EVERY > 0) begin : g_frame
      localparam int CW = $clog2(LAST_EVERY + 1);
      logic [CW-1:0] cnt_q, cnt_d;
      logic          lastHit;

      assign lastHit  = (cnt_q == CW'(LAST_EVERY - 1));
      assign out_last = out_valid && lastHit;

      always_comb begin
        cnt_d = cnt_q;
        if (flush)    cnt_d = '0;
        else if (pop) cnt_d = lastHit ? '0 : cnt_q + CW'(1);
      end

      always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end
    end else begin : g_noframe
      assign out_last = 1'b0;
    end
  endgenerate

`ifdef AFIFO_RD_STREAMER_STATS_EN
  logic [31:0] words_q;
  logic [31:0] stall_q;

  // Saturating counters; flush deliberately leaves them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      words_q <= 32'd0;
      stall_q <= 32'd0;
    end else begin
      if (pop && (words_q != 32'hFFFF_FFFF)) words_q <= words_q + 32'd1;
      if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
    end
  end

  assign words_out    = words_q;
  assign stall_cycles = stall_q;
`endif

endmodule
